muldiv_seq_unit: RTL and testbench
==================================

// Module: muldiv_seq_unit
// PURPOSE
// - Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
// - Accepts one M-extension op, stalls the pipeline while it iterates, returns a registered result.
// - One result bit per cycle; single-cycle outcomes for divide-by-zero and signed overflow.
// PARAMETERS
// - DATA_WIDTH     32  operand/result width; the iteration count equals DATA_WIDTH
// - OPCODE_LENGTH  3   width of Operation (RV32M funct3)
// PORTS
// - clk        in   1           single clock, rising edge
// - reset      in   1           asynchronous, active-high
// - start      in   1           EX holds a valid M-extension instruction
// - flush      in   1           pipeline flush; abort current op
// - Operation  in   3           000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - SrcA       in   DATA_WIDTH  rs1 value (multiplicand/dividend)
// - SrcB       in   DATA_WIDTH  rs2 value (multiplier/divisor)
// - stall      out  1           hold IF/ID/EX (combinational)
// - busy       out  1           FSM not in IDLE (registered state decode)
// - done       out  1           result valid this cycle; 1-cycle pulse
// - Result     out  DATA_WIDTH  registered result
// BEHAVIOUR
// - Reset (async): state=IDLE, Result=0, done=0, busy=0, all internal regs 0; stall=0 unless start.
// - FSM states: IDLE, PREP, CALC, FIX, DONE.
// - IDLE -> PREP when start=1 and flush=0: latch Operation, SrcA, SrcB.
// - PREP: take absolute values per signedness (MULH: both signed; MULHSU: A only; DIV/REM: both);
//   record result sign; clear accumulator; count=0.
//   - Divide, SrcB==0 -> DONE: DIV/DIVU Result=all ones; REM/REMU Result=SrcA.
//   - DIV/REM, SrcA==0x8000_0000 and SrcB==all ones -> DONE: DIV Result=0x8000_0000; REM Result=0.
//   - Otherwise -> CALC.
// - CALC: one shift-add (mul, 2*DATA_WIDTH product) or restoring shift-subtract (div) step per cycle.
//   After DATA_WIDTH steps (count==DATA_WIDTH-1) -> FIX.
// - FIX:
//   - Two's-complement negate if sign flag set. Quotient sign = signA^signB; remainder sign = signA.
//   - Select low word (MUL) or high word (MULH*); write Result. -> DONE.
// - DONE: done=1 for this cycle; Result stable; -> IDLE unconditionally. start is ignored in DONE
//   because the same instruction is leaving EX.
// - stall = (IDLE & start & ~flush) | PREP | CALC | FIX. stall=0 in DONE, so the pipeline advances
//   and captures Result.
// - Latency: start at cycle t; normal op done at t+DATA_WIDTH+3 (t+35); special case done at t+2.
// - Result holds its last value until the next FIX or special-case write; never changes in IDLE.
// - flush in any state: next state IDLE; no done pulse; Result unchanged; stall=0 that cycle.
// - flush and start together in IDLE: op not accepted.
// - Back-to-back ops: second start is sampled in the IDLE cycle after DONE (one bubble minimum).
// - Reset mid-operation: immediate IDLE, outputs to reset values; no partial result visible.
// - Widths: product accumulator 2*DATA_WIDTH; remainder register DATA_WIDTH+1 for the subtract borrow;
//   counter $clog2(DATA_WIDTH) bits, no wrap past DATA_WIDTH-1.
// STRUCTURE
// - Package muldiv_pkg:
//   - localparams for the eight funct3 codes (MD_MUL..MD_REMU)
//   - typedef enum logic [2:0] md_state_t {IDLE, PREP, CALC, FIX, DONE}
//   - helper functions is_div(op) and is_signed_a/b(op)
// - One sub-module muldiv_step: combinational single iteration
//   (inputs acc, operand, is_div; outputs next acc/quotient bit).
// - Top holds the FSM, counter, sign flags and Result register.
// TESTING
// - MUL 7*(-3): start at t -> stall t..t+34, done at t+35, Result=0xFFFF_FFEB; stall=0 at t+35.
// - MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000; MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE;
//   MULHSU (-1)*0xFFFF_FFFF -> 0xFFFF_FFFF.
// - DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at t+35.
// - DIV 5/0 -> 0xFFFF_FFFF and REM 5/0 -> 5, done at t+2;
//   DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0, done at t+2.
// - flush at t+10 of a DIV -> IDLE at t+11, no done pulse, Result keeps prior value;
//   new start at t+11 completes normally.
// - Reset asserted asynchronously mid-CALC -> busy, done, Result = 0 before the next clk edge;
//   back-to-back MUL ops -> second done 36 cycles after first.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Purpose: shared definitions for the iterative RV32M multiply/divide unit.
// Contents: funct3 opcode constants, FSM state type and opcode decode helpers.
package muldiv_pkg;

    localparam int unsigned MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MUL    = 3'b000;
    localparam logic [MD_OP_W-1:0] MD_MULH   = 3'b001;
    localparam logic [MD_OP_W-1:0] MD_MULHSU = 3'b010;
    localparam logic [MD_OP_W-1:0] MD_MULHU  = 3'b011;
    localparam logic [MD_OP_W-1:0] MD_DIV    = 3'b100;
    localparam logic [MD_OP_W-1:0] MD_DIVU   = 3'b101;
    localparam logic [MD_OP_W-1:0] MD_REM    = 3'b110;
    localparam logic [MD_OP_W-1:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

    // Divide/remainder family (funct3[2] set).
    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return op[2];
    endfunction

    // REM/REMU select the remainder rather than the quotient.
    function automatic logic is_rem(input logic [MD_OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed.
    function automatic logic is_signed_a(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed.
    function automatic logic is_signed_b(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Purpose: one combinational iteration of the multiply/divide datapath.
// Ports:
//   i_acc     accumulator; mul = {0, product_hi, multiplier/product_lo},
//             div = {remainder (W+1), dividend/quotient (W)}
//   i_operand multiplicand (mul) or divisor (div), magnitude only
//   i_is_div  select restoring shift-subtract instead of shift-add
//   o_acc     accumulator after this step (quotient bit enters at bit 0)
module muldiv_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH:0]  i_acc,
    input  logic [DATA_WIDTH-1:0]  i_operand,
    input  logic                   i_is_div,
    output logic [2*DATA_WIDTH:0]  o_acc
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] w_sum;
    logic [W:0] w_rshift;
    logic [W:0] w_diff;
    logic       w_q_bit;

    // Remainder stays below the divisor, so a W+1 bit difference has its
    // top bit set exactly when the trial subtraction borrows.
    always_comb begin
        w_sum    = i_acc[2*W:W] + (i_acc[0] ? {1'b0, i_operand} : {(W+1){1'b0}});
        w_rshift = {i_acc[2*W-1:W], i_acc[W-1]};
        w_diff   = w_rshift - {1'b0, i_operand};
        w_q_bit  = ~w_diff[W];
        o_acc    = '0;
        if (i_is_div) begin
            o_acc = {(w_q_bit ? w_diff : w_rshift), i_acc[W-2:0], w_q_bit};
        end else begin
            o_acc = {1'b0, w_sum, i_acc[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Purpose: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//   Stalls the pipeline while iterating one bit per cycle and returns a
//   registered result with a one-cycle done pulse.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start, flush      valid M-op in EX; abort current op
//   Operation         RV32M funct3
//   SrcA, SrcB        rs1 / rs2 values
//   stall             hold IF/ID/EX (combinational)
//   busy, done        FSM not idle; result valid this cycle
//   Result            registered result
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     flush,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned ACC_W = 2*DATA_WIDTH + 1;

    md_state_t              r_state;
    md_state_t              w_next;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W-1:0]           r_opnd;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_neg;
    logic [W-1:0]           r_result;

    logic [MD_OP_W-1:0]     w_op;
    logic                   w_div;
    logic                   w_rem;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [W-1:0]           w_abs_a;
    logic [W-1:0]           w_abs_b;
    logic                   w_div0;
    logic                   w_ovf;
    logic                   w_special;
    logic [W-1:0]           w_special_res;
    logic                   w_last;
    logic [ACC_W-1:0]       w_step_acc;
    logic [2*W-1:0]         w_prod;
    logic [W-1:0]           w_quo_rem;
    logic [W-1:0]           w_fix_res;

    // Operand decode, magnitudes and single-cycle special cases.
    always_comb begin
        w_op     = MD_OP_W'(r_op);
        w_div    = is_div(w_op);
        w_rem    = is_rem(w_op);
        w_neg_a  = is_signed_a(w_op) & r_a[W-1];
        w_neg_b  = is_signed_b(w_op) & r_b[W-1];
        w_abs_a  = w_neg_a ? (~r_a + W'(1)) : r_a;
        w_abs_b  = w_neg_b ? (~r_b + W'(1)) : r_b;
        w_div0   = w_div & (r_b == '0);
        w_ovf    = w_div & is_signed_a(w_op) & (r_a == {1'b1, {(W-1){1'b0}}}) & (r_b == '1);
        w_special = w_div0 | w_ovf;
        if (w_div0) begin
            w_special_res = w_rem ? r_a : '1;
        end else begin
            w_special_res = w_rem ? '0 : r_a;
        end
        w_last   = (r_cnt == CNT_W'(W-1));
    end

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_is_div  (w_div),
        .o_acc     (w_step_acc)
    );

    // Sign fix-up and word select at the end of iteration.
    always_comb begin
        w_prod    = r_neg ? (~r_acc[2*W-1:0] + (2*W)'(1)) : r_acc[2*W-1:0];
        w_quo_rem = w_rem ? r_acc[2*W-1:W] : r_acc[W-1:0];
        if (w_div) begin
            w_fix_res = r_neg ? (~w_quo_rem + W'(1)) : w_quo_rem;
        end else if (w_op == MD_MUL) begin
            w_fix_res = w_prod[W-1:0];
        end else begin
            w_fix_res = w_prod[2*W-1:W];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = w_special ? DONE : CALC;
            CALC:    if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
        end
    end

    // Status outputs; DONE releases the stall so the pipeline captures Result.
    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (r_state)
            IDLE:             stall = start & ~flush;
            PREP, CALC, FIX: begin
                stall = ~flush;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (!flush) begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= Operation;
                        r_a  <= SrcA;
                        r_b  <= SrcB;
                    end
                end
                PREP: begin
                    r_cnt  <= '0;
                    r_neg  <= w_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
                    // mul: multiplicand |A|, multiplier |B| in the low word
                    // div: divisor |B|, dividend |A| in the low word
                    r_opnd <= w_div ? w_abs_b : w_abs_a;
                    r_acc  <= {{(W+1){1'b0}}, (w_div ? w_abs_a : w_abs_b)};
                    if (w_special) begin
                        r_result <= w_special_res;
                    end
                end
                CALC: begin
                    r_acc <= w_step_acc;
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIX:     r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Purpose: directed self-checking bench for muldiv_seq_unit; expected values
//   are hand-computed RV32M results and cycle latencies.
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done = 0;

    muldiv_seq_unit #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .Result    (Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op in the current cycle (t), wait for done, check latency,
    // result and stall profile, then step into the following IDLE cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   n;
        int   bad;
        logic seen;
        n    = 0;
        bad  = 0;
        seen = 1'b0;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        start     = 1'b1;
        #1;
        chk({tag, "_stall_t"}, 32'(stall), 32'd1);
        while (n < 60 && !seen) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
            else if (stall !== 1'b1) bad++;
        end
        last_done = cyc;
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, Result, exp_res);
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_stall_hold"}, 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int   d1;
        logic seen_done;
        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        Operation = 3'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_result", Result,     32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);

        // Divides
        run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("divu", 3'b101, 32'd100,       32'd7, 32'd14,        35);
        run_op("remu", 3'b111, 32'd100,       32'd7, 32'd2,         35);

        // Single-cycle special cases
        run_op("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_op("rem0",   3'b110, 32'd5,         32'd0,         32'd5,         2);
        run_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_op("remu0",  3'b111, 32'd9,         32'd0,         32'd9,         2);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        // Flush mid-DIV: Result must keep 14 from the DIVU
        run_op("pre_fl", 3'b101, 32'd100, 32'd7, 32'd14, 35);
        Operation = 3'b100;
        SrcA      = 32'hFFFF_FFF9;
        SrcB      = 32'd2;
        start     = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_busy",   32'(busy),      32'd0);
        chk("fl_nodone", 32'(seen_done | done), 32'd0);
        chk("fl_result", Result,         32'd14);
        run_op("post_fl", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);

        // Asynchronous reset mid-CALC
        Operation = 3'b000;
        SrcA      = 32'd3;
        SrcB      = 32'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy",   32'(busy),  32'd0);
        chk("ar_done",   32'(done),  32'd0);
        chk("ar_stall",  32'(stall), 32'd0);
        chk("ar_result", Result,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back MULs: second done 36 cycles after the first
        run_op("b2b1", 3'b000, 32'd6,      32'd7,      32'd42,        35);
        d1 = last_done;
        run_op("b2b2", 3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 35);
        chk("b2b_gap", 32'(last_done - d1), 32'd36);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
